// File: rtl/double_ge_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : double_ge_arbiter_pkg
//  Description : Shared constants and the per-requester state encoding for
//                the double_ge arbiter and its comparator.
//                  DOUBLE_W    - width of an IEEE-754 binary64 operand
//                  DGE_LATENCY - pipeline depth of the double_ge comparator
//                  req_state_t - per-requester FSM state (IDLE/BUSY/DONE)
//  Revision    : 1.0 - initial release
// ============================================================================
package double_ge_arbiter_pkg;

    localparam int DOUBLE_W    = 64;
    localparam int DGE_LATENCY = 2;

    typedef logic [1:0] req_state_t;

    localparam req_state_t ST_IDLE = 2'd0;  // free to accept a new compare
    localparam req_state_t ST_BUSY = 2'd1;  // compare in flight
    localparam req_state_t ST_DONE = 2'd2;  // result held until consumed

endpackage : double_ge_arbiter_pkg
`default_nettype wire

// File: rtl/double_ge_arbiter_double_ge.sv
`default_nettype none
// ============================================================================
//  Module      : double_ge_arbiter_double_ge
//  Description : Pipelined IEEE-754 binary64 "a >= b" comparator.
//                Result for operands presented in cycle t appears on o_z in
//                cycle t+LATENCY. No reset: downstream logic qualifies o_z.
//  Ports       : clk  - clock, rising edge
//                i_a  - operand a (binary64)
//                i_b  - operand b (binary64)
//                o_z  - 1 when a >= b; 0 when either operand is NaN
//  Revision    : 1.0 - initial release
// ============================================================================
module double_ge_arbiter_double_ge
    import double_ge_arbiter_pkg::*;
#(
    parameter int LATENCY = DGE_LATENCY
) (
    input  logic                clk,
    input  logic [DOUBLE_W-1:0] i_a,
    input  logic [DOUBLE_W-1:0] i_b,
    output logic                o_z
);

    logic                w_a_nan;
    logic                w_b_nan;
    logic [DOUBLE_W-2:0] w_mag_a;
    logic [DOUBLE_W-2:0] w_mag_b;
    logic                w_sign_a;
    logic                w_sign_b;
    logic                w_both_zero;
    logic                w_ge;
    logic                r_pipe [LATENCY];

    // Bit layout: [63] sign, [62:52] exponent, [51:0] fraction.
    assign w_sign_a    = i_a[DOUBLE_W-1];
    assign w_sign_b    = i_b[DOUBLE_W-1];
    assign w_mag_a     = i_a[DOUBLE_W-2:0];
    assign w_mag_b     = i_b[DOUBLE_W-2:0];
    assign w_a_nan     = (&i_a[62:52]) & (|i_a[51:0]);
    assign w_b_nan     = (&i_b[62:52]) & (|i_b[51:0]);
    // +0 and -0 compare equal regardless of sign.
    assign w_both_zero = (w_mag_a == '0) & (w_mag_b == '0);

    always_comb begin
        w_ge = 1'b0;
        if (w_a_nan || w_b_nan) begin
            w_ge = 1'b0;
        end else if (w_both_zero) begin
            w_ge = 1'b1;
        end else if (w_sign_a != w_sign_b) begin
            w_ge = ~w_sign_a;
        end else if (!w_sign_a) begin
            w_ge = (w_mag_a >= w_mag_b);
        end else begin
            // Both negative: larger magnitude means smaller value.
            w_ge = (w_mag_a <= w_mag_b);
        end
    end

    for (genvar s = 0; s < LATENCY; s++) begin : g_pipe
        if (s == 0) begin : g_head
            always_ff @(posedge clk) begin
                r_pipe[s] <= w_ge;
            end
        end else begin : g_body
            always_ff @(posedge clk) begin
                r_pipe[s] <= r_pipe[s-1];
            end
        end
    end

    assign o_z = r_pipe[LATENCY-1];

endmodule : double_ge_arbiter_double_ge
`default_nettype wire

// File: rtl/double_ge_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : double_ge_arbiter
//  Description : Shares one pipelined double_ge comparator among N
//                requesters. Round-robin issue of at most one compare per
//                cycle, requester tag carried alongside the comparator
//                pipeline, and a per-requester result register held until
//                the requester consumes it.
//  Ports       : clk         - clock, rising edge
//                rst         - asynchronous active-high reset
//                req_valid   - [N]      operands present on slice i
//                req_ready   - [N]      one-hot grant (handshake = valid&ready)
//                req_a/req_b - [64*N]   operands, slice i = [64*i+63:64*i]
//                rsp_valid   - [N]      result held for requester i
//                rsp_ready   - [N]      requester i consumes its result
//                rsp_z       - [N]      result bit (1 = a >= b)
//                issue_count - [CNT_W]  accepted compares, wraps
//  Revision    : 1.0 - initial release
// ============================================================================
module double_ge_arbiter
    import double_ge_arbiter_pkg::*;
#(
    parameter int N       = 4,
    parameter int LATENCY = DGE_LATENCY,
    parameter int CNT_W   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          req_valid,
    output logic [N-1:0]          req_ready,
    input  logic [DOUBLE_W*N-1:0] req_a,
    input  logic [DOUBLE_W*N-1:0] req_b,
    output logic [N-1:0]          rsp_valid,
    input  logic [N-1:0]          rsp_ready,
    output logic [N-1:0]          rsp_z,
    output logic [CNT_W-1:0]      issue_count
);

    localparam int IDX_W = $clog2(N);
    localparam int SUM_W = IDX_W + 1;

    req_state_t          r_state     [N];
    req_state_t          w_state_nxt [N];
    logic                r_rsp_z     [N];
    logic [N-1:0]        w_elig;
    logic [N-1:0]        w_grant;
    logic [N-1:0]        w_cpl;
    logic                w_gnt_any;
    logic [IDX_W-1:0]    w_gnt_idx;
    logic [SUM_W-1:0]    w_rr_sum;
    logic [IDX_W-1:0]    w_rr_idx;
    logic [IDX_W-1:0]    r_ptr;
    logic                r_tag_vld   [LATENCY];
    logic [IDX_W-1:0]    r_tag_idx   [LATENCY];
    logic                w_tail_vld;
    logic [IDX_W-1:0]    w_tail_idx;
    logic [DOUBLE_W-1:0] w_dge_a;
    logic [DOUBLE_W-1:0] w_dge_b;
    logic                w_dge_z;
    logic [CNT_W-1:0]    r_issue_cnt;

    // ------------------------------------------------------------------
    // Round-robin grant: first eligible index at or after r_ptr, wrapping.
    // ------------------------------------------------------------------
    always_comb begin
        w_grant   = '0;
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_rr_sum  = '0;
        w_rr_idx  = '0;
        for (int k = 0; k < N; k++) begin
            w_rr_sum = {1'b0, r_ptr} + SUM_W'(k);
            if (w_rr_sum >= SUM_W'(N)) begin
                w_rr_sum = w_rr_sum - SUM_W'(N);
            end
            w_rr_idx = w_rr_sum[IDX_W-1:0];
            if (!w_gnt_any && w_elig[w_rr_idx]) begin
                w_gnt_any          = 1'b1;
                w_gnt_idx          = w_rr_idx;
                w_grant[w_rr_idx]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_gnt_any) begin
            r_ptr <= (w_gnt_idx == IDX_W'(N - 1)) ? '0 : w_gnt_idx + IDX_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Issue path: operands of the granted slice, zero when idle.
    // ------------------------------------------------------------------
    always_comb begin
        w_dge_a = '0;
        w_dge_b = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant[i]) begin
                w_dge_a = req_a[DOUBLE_W*i +: DOUBLE_W];
                w_dge_b = req_b[DOUBLE_W*i +: DOUBLE_W];
            end
        end
    end

    double_ge_arbiter_double_ge #(
        .LATENCY (LATENCY)
    ) u_double_ge (
        .clk (clk),
        .i_a (w_dge_a),
        .i_b (w_dge_b),
        .o_z (w_dge_z)
    );

    // ------------------------------------------------------------------
    // Tag shift register, same depth as the comparator pipeline, so the
    // tail tag lines up with the comparator output.
    // ------------------------------------------------------------------
    for (genvar s = 0; s < LATENCY; s++) begin : g_tag
        if (s == 0) begin : g_head
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_tag_vld[s] <= 1'b0;
                    r_tag_idx[s] <= '0;
                end else begin
                    r_tag_vld[s] <= w_gnt_any;
                    r_tag_idx[s] <= w_gnt_idx;
                end
            end
        end else begin : g_body
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_tag_vld[s] <= 1'b0;
                    r_tag_idx[s] <= '0;
                end else begin
                    r_tag_vld[s] <= r_tag_vld[s-1];
                    r_tag_idx[s] <= r_tag_idx[s-1];
                end
            end
        end
    end

    assign w_tail_vld = r_tag_vld[LATENCY-1];
    assign w_tail_idx = r_tag_idx[LATENCY-1];

    // ------------------------------------------------------------------
    // Per-requester FSM and result register.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < N; i++) begin : g_req
        // Grants are suppressed while reset is held so every output is 0.
        assign w_elig[i] = req_valid[i] & (r_state[i] == ST_IDLE) & ~rst;
        assign w_cpl[i]  = w_tail_vld & (w_tail_idx == IDX_W'(i));

        // State register
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state[i] <= ST_IDLE;
            end else begin
                r_state[i] <= w_state_nxt[i];
            end
        end

        // Next-state logic
        always_comb begin
            w_state_nxt[i] = r_state[i];
            case (r_state[i])
                ST_IDLE: if (w_grant[i])   w_state_nxt[i] = ST_BUSY;
                ST_BUSY: if (w_cpl[i])     w_state_nxt[i] = ST_DONE;
                ST_DONE: if (rsp_ready[i]) w_state_nxt[i] = ST_IDLE;
                default:                   w_state_nxt[i] = ST_IDLE;
            endcase
        end

        // Result capture at the end of the completion cycle.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_rsp_z[i] <= 1'b0;
            end else if (w_cpl[i]) begin
                r_rsp_z[i] <= w_dge_z;
            end
        end

        // Outputs
        assign rsp_valid[i] = (r_state[i] == ST_DONE);
        assign rsp_z[i]     = r_rsp_z[i];
    end

    assign req_ready = w_grant;

    // ------------------------------------------------------------------
    // Issue counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_issue_cnt <= '0;
        end else if (w_gnt_any) begin
            r_issue_cnt <= r_issue_cnt + CNT_W'(1);
        end
    end

    assign issue_count = r_issue_cnt;

endmodule : double_ge_arbiter
`default_nettype wire

// File: tb/tb_double_ge_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_double_ge_arbiter
//  Description : Self-checking bench for double_ge_arbiter (N=4, CNT_W=4).
//                Reference model tracks outstanding requests per requester,
//                a round-robin pointer and expected results computed with
//                real-number comparison.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_double_ge_arbiter;
    import double_ge_arbiter_pkg::*;

    localparam int N   = 4;
    localparam int LAT = DGE_LATENCY;
    localparam int CW  = 4;

    localparam logic [63:0] C_P0   = 64'h0000000000000000;
    localparam logic [63:0] C_N0   = 64'h8000000000000000;
    localparam logic [63:0] C_PINF = 64'h7FF0000000000000;
    localparam logic [63:0] C_NINF = 64'hFFF0000000000000;
    localparam logic [63:0] C_NAN  = 64'h7FF8000000000000;
    localparam logic [63:0] C_ONE  = 64'h3FF0000000000000;
    localparam logic [63:0] C_TWO  = 64'h4000000000000000;
    localparam logic [63:0] C_DEN  = 64'h0000000000000001;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      rsp_ready = '0;
    logic [64*N-1:0]   req_a = '0;
    logic [64*N-1:0]   req_b = '0;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      rsp_valid;
    logic [N-1:0]      rsp_z;
    logic [CW-1:0]     issue_count;

    double_ge_arbiter #(
        .N       (N),
        .LATENCY (LAT),
        .CNT_W   (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_z       (rsp_z),
        .issue_count (issue_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model state
    bit [N-1:0] m_out = '0;
    int         m_rdy [N];
    int         m_ptr = 0;
    int         m_cnt = 0;
    bit         exp_q [N][$];

    function automatic bit ref_ge(input logic [63:0] a, input logic [63:0] b);
        real ra;
        real rb;
        ra = $bitstoreal(a);
        rb = $bitstoreal(b);
        return (ra >= rb);
    endfunction

    function automatic logic [63:0] special(input int k);
        case (k)
            0:       return C_P0;
            1:       return C_N0;
            2:       return C_PINF;
            3:       return C_NINF;
            4:       return C_NAN;
            5:       return C_ONE;
            6:       return C_TWO;
            default: return C_DEN;
        endcase
    endfunction

    function automatic logic [63:0] pick_a();
        if ($urandom_range(0, 3) == 0) return special(int'($urandom_range(0, 7)));
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic [63:0] pick_b(input logic [63:0] a);
        case ($urandom_range(0, 4))
            0:       return a;
            1:       return a ^ 64'd1;
            2:       return a ^ 64'h8000000000000000;
            default: return pick_a();
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor / scoreboard: compare at the falling edge, then advance model.
    always @(negedge clk) begin
        int         g;
        int         j;
        bit         ev;
        logic [N-1:0] exp_gnt;
        if (rst) begin
            check("reset_outputs", {48'd0, req_ready, rsp_valid, rsp_z, issue_count}, 64'd0);
            m_out = '0;
            m_ptr = 0;
            m_cnt = 0;
            for (int i = 0; i < N; i++) exp_q[i].delete();
        end else begin
            g       = -1;
            exp_gnt = '0;
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (g < 0 && req_valid[j] && !m_out[j]) g = j;
            end
            if (g >= 0) exp_gnt[g] = 1'b1;
            check("req_ready", {60'd0, req_ready}, {60'd0, exp_gnt});
            check("issue_count", {60'd0, issue_count}, 64'(m_cnt));
            for (int i = 0; i < N; i++) begin
                ev = m_out[i] && (cyc >= m_rdy[i]);
                check($sformatf("rsp_valid[%0d]", i), {63'd0, rsp_valid[i]}, {63'd0, ev});
                if (ev) begin
                    if (exp_q[i].size() == 0) begin
                        check($sformatf("scoreboard_empty[%0d]", i), 64'd0, 64'd1);
                    end else begin
                        check($sformatf("rsp_z[%0d]", i), {63'd0, rsp_z[i]}, {63'd0, exp_q[i][0]});
                        if (rsp_ready[i]) begin
                            void'(exp_q[i].pop_front());
                            m_out[i] = 1'b0;
                        end
                    end
                end
            end
            if (g >= 0) begin
                m_out[g] = 1'b1;
                m_rdy[g] = cyc + LAT + 1;
                exp_q[g].push_back(ref_ge(req_a[64*g +: 64], req_b[64*g +: 64]));
                m_ptr    = (g + 1) % N;
                m_cnt    = (m_cnt + 1) % (1 << CW);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [63:0] a, input logic [63:0] b);
        req_a[64*i +: 64] = a;
        req_b[64*i +: 64] = b;
    endtask

    task automatic drain(input int n);
        req_valid = '0;
        rsp_ready = '1;
        step(n);
    endtask

    initial begin
        for (int i = 0; i < N; i++) m_rdy[i] = 0;
        rst = 1'b1;
        step(3);
        rst = 1'b0;

        // Single request on requester 0: 2.0 >= 1.0, held then consumed.
        set_ops(0, C_TWO, C_ONE);
        req_valid = 4'b0001;
        rsp_ready = 4'b0000;
        step(1);
        req_valid = 4'b0000;
        step(6);
        drain(4);

        // Requester 3 alone moves the pointer back to 0.
        set_ops(3, C_ONE, C_TWO);
        req_valid = 4'b1000;
        step(1);
        drain(6);

        // Special values, all requesters contending with pointer at 0.
        set_ops(0, C_N0, C_P0);
        set_ops(1, C_NAN, C_ONE);
        set_ops(2, C_PINF, C_PINF);
        set_ops(3, C_NINF, C_DEN);
        req_valid = 4'b1111;
        rsp_ready = 4'b1111;
        step(12);
        drain(6);

        // Backpressure on requester 1 while everyone keeps requesting.
        req_valid = 4'b1111;
        rsp_ready = 4'b1101;
        for (int c = 0; c < 16; c++) begin
            for (int i = 0; i < N; i++) set_ops(i, pick_a(), pick_a());
            step(1);
        end
        rsp_ready = 4'b1111;
        step(2);
        drain(6);

        // Reset one cycle after a grant to requester 2.
        set_ops(2, C_TWO, C_ONE);
        req_valid = 4'b0100;
        step(1);
        req_valid = 4'b0000;
        step(1);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        rsp_ready = 4'b0000;
        step(6);
        drain(2);

        // Randomized traffic; CW=4 makes issue_count wrap repeatedly.
        for (int c = 0; c < 400; c++) begin
            req_valid = 4'($urandom());
            for (int i = 0; i < N; i++) begin
                logic [63:0] a;
                a = pick_a();
                set_ops(i, a, pick_b(a));
                rsp_ready[i] = ($urandom_range(0, 3) != 0);
            end
            step(1);
        end
        drain(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_double_ge_arbiter
`default_nettype wire

// File: doc/double_ge_arbiter.md
Name: double_ge_arbiter

Overview:
Shares one pipelined double_ge comparator (IEEE-754 binary64 a >= b, fixed 2-cycle latency) among N requesters. Accepts at most one compare per cycle using round-robin arbitration and tags each issue with its requester index through a delay line that matches the comparator latency. Holds each result in a per-requester register until that requester accepts it. Sits between the scalar FP clients and the shared comparator instance.

Parameters:
N, 4, number of requesters (2..8)
LATENCY, 2, comparator latency in cycles; must equal the double_ge pipeline depth
CNT_W, 32, width of the issue counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  N  requester i has operands on req_a/req_b slice i
req_ready  out  N  one-hot grant; handshake when req_valid[i] & req_ready[i]
req_a  in  64*N  operand a, slice i = bits [64*i+63:64*i]
req_b  in  64*N  operand b, same slicing
rsp_valid  out  N  result held for requester i
rsp_ready  in  N  requester i consumes its result
rsp_z  out  N  result bit for requester i (1 = a >= b)
issue_count  out  CNT_W  total accepted compares, wraps modulo 2^CNT_W

Behaviour:
- Reset is asynchronous and active-high. All outputs reset to 0. Per-requester state resets to IDLE. Round-robin pointer resets to 0. Tag pipeline valid bits clear. Any in-flight or held results are discarded. The double_ge instance has no reset; its stale outputs are ignored because tag valid bits are 0.
- Per-requester FSM:
  - IDLE -> BUSY on a handshake.
  - BUSY -> DONE when the tag pipeline delivers index i.
  - DONE -> IDLE on rsp_ready[i].
- Eligibility: requester i is eligible when req_valid[i] is high and its state is IDLE.
- req_ready is combinational from eligibility, state and pointer. It must not depend on rsp_ready.
- Arbitration:
  - Grant the first eligible index at or after the pointer, searching upward with wrap modulo N.
  - At most one grant per cycle.
  - On a grant to index g, the pointer becomes (g+1) mod N at the next edge. With no grant, the pointer holds.
- Issue path:
  - In the handshake cycle t, double_ge_a and double_ge_b are driven combinationally from the granted slices.
  - With no grant, both are driven to 64'd0.
  - The tag (valid, index) enters a LATENCY-deep shift register at edge t.
- Completion:
  - The comparator output is valid in cycle t+LATENCY, coinciding with the tag at the pipeline tail.
  - At the end of that cycle, z is captured into rsp_z[index] and the state moves to DONE.
  - rsp_valid[index] is high from cycle t+LATENCY+1.
- rsp_valid[i] = (state == DONE). rsp_z[i] holds stable while rsp_valid[i] is high.
- A requester in DONE that sees rsp_ready[i] goes to IDLE next cycle. It cannot be granted in that same cycle.
  - Minimum reissue interval per requester: LATENCY+2 cycles.
  - Aggregate throughput: 1 compare per cycle.
- rsp_ready[i] while not in DONE is ignored.
- Simultaneous events:
  - A completion for i and a grant to j≠i in the same cycle both take effect.
  - A completion cannot coincide with a grant to the same index, because that index is not IDLE.
- issue_count increments on every handshake.
- Operand slices are sampled only in the handshake cycle. Later changes on req_a/req_b have no effect.

Decomposition:
- Shared package holds:
  - the double-width constant (64)
  - the per-requester state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2)
  - the double_ge latency constant (2), which the LATENCY default references
- One sub-module is natural: the existing double_ge, instantiated once. The arbiter adds the round-robin grant logic, tag shift register, per-requester FSMs and result registers.
- The dq delay module may implement the tag shift register only if it is given reset. Otherwise use a local reset-capable shift register.

Test Plan:
- Single request: N=4, req_valid=0001, a=0x4000000000000000 (2.0), b=0x3FF0000000000000 (1.0) → req_ready[0]=1 in cycle 0; rsp_valid[0] rises in cycle 3 with rsp_z[0]=1; issue_count=1.
- All four requesters valid with rsp_ready=1111 and pointer 0 → grants in order 0,1,2,3 on consecutive cycles; then 0 again no earlier than cycle 4 after its first grant.
- Special values: a=-0.0 (0x8000000000000000), b=+0.0 → rsp_z=1. a=NaN (0x7FF8000000000000), b=1.0 → rsp_z=0. a=+inf, b=+inf → rsp_z=1.
- Backpressure: rsp_ready[1]=0 for 10 cycles after completion → rsp_valid[1] and rsp_z[1] stay stable; req_valid[1]=1 gets no grant; requesters 0, 2 and 3 continue to be served.
- Reset mid-flight: assert rst one cycle after a grant to 2 → rsp_valid stays 0000 after reset release; no late completion appears; issue_count=0.
- Counter wrap: CNT_W=4, 17 handshakes → issue_count=1.
